conv_requant_pool: RTL
======================

# conv_requant_pool

Post-processing stage that sits directly downstream of `matrix_convolution`. It captures the 4x4 signed 16-bit convolution result when the convolution reports done, then for each element adds a per-tile bias, applies ReLU, applies a rounding right-shift and saturates to int8. It then 2x2 max-pools the 16 values to 4 int8 values and streams them out over a valid/ready handshake to the next layer's buffer.

## Interface
Parameters:
- `DATA_W`, 16, width of each convolution result and of the bias.
- `OUT_W`, 8, width of each output sample (signed int8 range; only 0..127 can occur).

Ports:
- `clk`  in  1  single clock. Everything is synchronous to its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `conv_done`  in  1  one-cycle pulse from the convolution stage; `c` is valid in that cycle.
- `c`  in  signed [DATA_W-1:0] [0:3][0:3]  convolution result tile.
- `bias`  in  signed [DATA_W-1:0]  sampled together with `c`.
- `shift`  in  [3:0]  requant right-shift, 0..15, sampled together with `c`.
- `out_valid`  out  1  pooled sample available.
- `out_ready`  in  1  downstream accepts the sample.
- `out_data`  out  signed [OUT_W-1:0]  pooled sample.
- `out_last`  out  1  marks the 4th sample of a tile.
- `busy`  out  1  a tile is held (any state other than IDLE).
- `tile_done`  out  1  one-cycle pulse after the last handshake of a tile.
- `tile_sat`  out  1  at least one element saturated in the tile just finished. Valid with `tile_done`; held until the next capture.
- `overrun`  out  1  sticky: a `conv_done` arrived while `busy`. Cleared only by `rst`.

## Operation
- States: IDLE, PROC, EMIT, FIN.
- **IDLE**
  - On `conv_done`, latch `c`, `bias` and `shift` into local registers.
  - Clear the element counter, the window max and `tile_sat`; go to PROC.
- **PROC**, one element per cycle, in window order:
  - W0: (0,0) (0,1) (1,0) (1,1)
  - W1: (0,2) (0,3) (1,2) (1,3)
  - W2: (2,0) (2,1) (3,0) (3,1)
  - W3: (2,2) (2,3) (3,2) (3,3)
- **Element arithmetic**
  - s = c + bias, computed at 17-bit signed width. No wrap is allowed.
  - ReLU: s < 0 gives 0.
  - Round: if shift > 0, r = (s + 2^(shift-1)) >> shift. If shift = 0, r = s. Use at least 18 bits unsigned.
  - Saturate: r > 127 gives 127 and sets `tile_sat`.
- **Pooling**
  - The first element of a window loads the window max; the next three update it with max.
  - After the 4th element, load the max into `out_data`, assert `out_valid`, and go to EMIT.
- **EMIT**
  - Hold `out_data`, `out_valid` and `out_last` stable until `out_valid && out_ready`.
  - On that handshake: W0–W2 go to PROC for the next window; W3 goes to FIN.
  - `out_last` = 1 only for the W3 sample.
- **FIN**: pulse `tile_done` for one cycle, then return to IDLE.
- `conv_done` while not in IDLE: ignored, captured data unchanged, `overrun` set.
- `rst` in any state, including mid-PROC or mid-EMIT: the tile is abandoned.

## Timing
- Reset values: `out_valid` = 0, `out_data` = 0, `out_last` = 0, `busy` = 0, `tile_done` = 0, `tile_sat` = 0, `overrun` = 0. State = IDLE.
- `conv_done` in cycle T:
  - `busy` = 1 from T+1.
  - PROC covers W0 in T+1..T+4.
  - `out_valid` = 1 from T+5.
- With `out_ready` held high:
  - Samples appear at T+5, T+10, T+15, T+20 (each handshake cycle is followed by 4 PROC cycles).
  - `tile_done` pulses at T+21; `busy` = 0 from T+22.
- With backpressure: PROC never advances while in EMIT; no sample is lost or duplicated.
- `conv_done` in the same cycle as `tile_done`: counts as an overrun and is ignored. The earliest accepted `conv_done` is the first cycle with `busy` = 0.

## Structure
- Shared package `npu_pkg`:
  - constants `CONV_OUT_DIM` = 4 and `POOL_DIM` = 2
  - typedefs `conv_out_t` (signed 16-bit) and `q8_t` (signed 8-bit)
  - state enum `crp_state_e`
- One combinational sub-module, `requant_relu_sat`: inputs (c, bias, shift); outputs (q8 value, sat flag).
- The FSM, counter, tile registers and max register live in the top level.

## Test plan
- c = 10 everywhere, bias = 0, shift = 0, `out_ready` = 1 → samples 10, 10, 10, 10; `out_last` only on the 4th; `tile_done` at T+21; `tile_sat` = 0.
- Max pooling: c[0][0] = -5, c[0][1] = 7, c[1][0] = 3, c[1][1] = 2, all others 0, bias = 0, shift = 0 → samples 7, 0, 0, 0.
- Requant and ReLU:
  - c = 1000 everywhere, shift = 2 → 250 saturates to 127 with `tile_sat` = 1.
  - shift = 4 → 63 (1000/16 = 62.5 rounds to 63).
  - bias = -2000 → all samples 0.
- Rounding: c = 6, shift = 2 → 2; c = 5, shift = 2 → 1; c = 32767 with bias = 32767, shift = 15 → 2 (no 17-bit overflow).
- Backpressure:
  - Drop `out_ready` for 10 cycles after the first sample → `out_data` and `out_valid` stay stable, no extra samples.
  - Pulse `conv_done` during this → `overrun` = 1 and output values unchanged.
- Reset mid-EMIT → next cycle all outputs at reset values. A subsequent `conv_done` with c = 20 yields 20, 20, 20, 20.

Source files
------------

// File: rtl/npu_pkg.sv
// Shared types and constants for the NPU post-convolution datapath.
package npu_pkg;

    localparam int CONV_OUT_DIM = 4;
    localparam int POOL_DIM     = 2;

    typedef logic signed [15:0] conv_out_t;
    typedef logic signed [7:0]  q8_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PROC = 2'd1,
        ST_EMIT = 2'd2,
        ST_FIN  = 2'd3
    } crp_state_e;

endpackage

// File: rtl/conv_requant_pool_if.sv
// Tile input, pooled-sample stream and status bundle for conv_requant_pool.
interface conv_requant_pool_if #(
    parameter int DATA_W = 16,
    parameter int OUT_W  = 8
);
    logic                                 conv_done;
    logic [0:3][0:3][DATA_W-1:0]          c;
    logic signed [DATA_W-1:0]             bias;
    logic [3:0]                           shift;
    logic                                 out_valid;
    logic                                 out_ready;
    logic signed [OUT_W-1:0]              out_data;
    logic                                 out_last;
    logic                                 busy;
    logic                                 tile_done;
    logic                                 tile_sat;
    logic                                 overrun;

    modport master (
        output conv_done, c, bias, shift, out_ready,
        input  out_valid, out_data, out_last, busy, tile_done, tile_sat, overrun
    );

    modport slave (
        input  conv_done, c, bias, shift, out_ready,
        output out_valid, out_data, out_last, busy, tile_done, tile_sat, overrun
    );
endinterface

// File: rtl/conv_requant_pool_requant_relu_sat.sv
// Per-element bias add, ReLU, rounding right-shift and saturation to the
// positive int8 range. Purely combinational.
module requant_relu_sat #(
    parameter int DATA_W = 16,
    parameter int OUT_W  = 8
) (
    input  logic signed [DATA_W-1:0] c_i,
    input  logic signed [DATA_W-1:0] bias_i,
    input  logic [3:0]               shift_i,
    output logic signed [OUT_W-1:0]  q_o,
    output logic                     sat_o
);
    localparam int RW = DATA_W + 2;
    localparam logic [RW-1:0] Q_MAX = RW'((2 ** (OUT_W - 1)) - 1);
    localparam logic [RW-1:0] ONE   = RW'(1);

    logic [DATA_W:0] sum_s;
    logic [RW-1:0]   relu_s;
    logic [RW-1:0]   half_s;
    logic [RW-1:0]   rnd_s;

    // Sum is one bit wider than the operands so c + bias never wraps.
    always_comb begin
        sum_s = {c_i[DATA_W-1], c_i} + {bias_i[DATA_W-1], bias_i};
        if (sum_s[DATA_W]) begin
            relu_s = '0;
        end else begin
            relu_s = {1'b0, sum_s};
        end
        if (shift_i == 4'd0) begin
            half_s = '0;
        end else begin
            half_s = ONE << (shift_i - 4'd1);
        end
        rnd_s = (relu_s + half_s) >> shift_i;
        if (rnd_s > Q_MAX) begin
            q_o   = Q_MAX[OUT_W-1:0];
            sat_o = 1'b1;
        end else begin
            q_o   = rnd_s[OUT_W-1:0];
            sat_o = 1'b0;
        end
    end

endmodule

// File: rtl/conv_requant_pool.sv
// Captures a 4x4 convolution tile, requantises each element to int8 and
// streams the four 2x2 max-pooled results over a valid/ready handshake.
module conv_requant_pool
    import npu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int OUT_W  = 8
) (
    input logic               clk,
    input logic               rst,
    conv_requant_pool_if.slave bus
);
    crp_state_e                                          state_q, state_d;
    logic [0:CONV_OUT_DIM-1][0:CONV_OUT_DIM-1][DATA_W-1:0] c_q, c_d;
    logic signed [DATA_W-1:0]                            bias_q, bias_d;
    logic [3:0]                                          shift_q, shift_d;
    logic [3:0]                                          cnt_q, cnt_d;
    logic signed [OUT_W-1:0]                             max_q, max_d;
    logic signed [OUT_W-1:0]                             out_data_q, out_data_d;
    logic out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic busy_q, busy_d, tile_done_q, tile_done_d;
    logic tile_sat_q, tile_sat_d, overrun_q, overrun_d;

    logic [1:0]              row_s, col_s;
    logic signed [OUT_W-1:0] q_s, win_max_s;
    logic                    sat_s;

    // Counter bits {3,2} pick the window, bits {1,0} the element inside it.
    assign row_s = {cnt_q[3], cnt_q[1]};
    assign col_s = {cnt_q[2], cnt_q[0]};

    requant_relu_sat #(.DATA_W(DATA_W), .OUT_W(OUT_W)) u_requant (
        .c_i    (c_q[row_s][col_s]),
        .bias_i (bias_q),
        .shift_i(shift_q),
        .q_o    (q_s),
        .sat_o  (sat_s)
    );

    assign win_max_s = ((cnt_q[1:0] == 2'd0) || (q_s > max_q)) ? q_s : max_q;

    // Next-state and datapath update.
    always_comb begin
        state_d     = state_q;
        c_d         = c_q;
        bias_d      = bias_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        max_d       = max_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        tile_sat_d  = tile_sat_q;
        overrun_d   = overrun_q | (bus.conv_done && (state_q != ST_IDLE));
        case (state_q)
            ST_IDLE: begin
                if (bus.conv_done) begin
                    c_d        = bus.c;
                    bias_d     = bus.bias;
                    shift_d    = bus.shift;
                    cnt_d      = 4'd0;
                    max_d      = '0;
                    tile_sat_d = 1'b0;
                    state_d    = ST_PROC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PROC: begin
                cnt_d      = cnt_q + 4'd1;
                max_d      = win_max_s;
                tile_sat_d = tile_sat_q | sat_s;
                if (cnt_q[1:0] == 2'd3) begin
                    out_data_d  = win_max_s;
                    out_valid_d = 1'b1;
                    out_last_d  = (cnt_q == 4'd15);
                    state_d     = ST_EMIT;
                end else begin
                    state_d = ST_PROC;
                end
            end
            ST_EMIT: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    state_d     = out_last_q ? ST_FIN : ST_PROC;
                end else begin
                    state_d = ST_EMIT;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d      = (state_d != ST_IDLE);
        tile_done_d = (state_d == ST_FIN);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            c_q         <= '0;
            bias_q      <= '0;
            shift_q     <= 4'd0;
            cnt_q       <= 4'd0;
            max_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            tile_done_q <= 1'b0;
            tile_sat_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            c_q         <= c_d;
            bias_q      <= bias_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            max_q       <= max_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            tile_done_q <= tile_done_d;
            tile_sat_q  <= tile_sat_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.busy      = busy_q;
    assign bus.tile_done = tile_done_q;
    assign bus.tile_sat  = tile_sat_q;
    assign bus.overrun   = overrun_q;

endmodule
